// File: rtl/imem_loader.sv
// Loads a length-prefixed stream of 32-bit instruction words big-endian into a byte
// array and keeps the core in reset until the whole image has arrived.
module imem_loader #(
    parameter int DEPTH_BYTES = 256,
    parameter int MAX_WORDS   = DEPTH_BYTES / 4,
    parameter int LEN_W       = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [7:0]       instruction_mem [DEPTH_BYTES],
    output logic             core_reset,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [31:0]      checksum_q, checksum_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             in_ready_q, in_ready_d;
    logic             core_reset_q, core_reset_d;
    logic [7:0]       mem_q [DEPTH_BYTES];
    logic [7:0]       mem_d [DEPTH_BYTES];

    logic len_ok;
    logic accept;

    assign len_ok = (len_words != '0) && (len_words <= LEN_W'(MAX_WORDS));
    assign accept = (state_q == LOAD) && in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        words_left_d = words_left_q;
        checksum_d   = checksum_q;
        error_d      = error_q;
        mem_d        = mem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d      = LOAD;
                        wr_addr_d    = '0;
                        words_left_d = len_words;
                        checksum_d   = '0;
                        error_d      = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    // most significant byte lands at the lowest address
                    for (int b = 0; b < 4; b++)
                        mem_d[wr_addr_q + AW'(b)] = in_data[31-8*b -: 8];
                    wr_addr_d    = wr_addr_q + AW'(4);
                    words_left_d = words_left_q - 1'b1;
                    checksum_d   = checksum_q ^ in_data;
                    if (words_left_q == LEN_W'(1))
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // status outputs are registered images of the next state
        in_ready_d   = (state_d == LOAD);
        done_d       = (state_d == DONE);
        core_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            words_left_q <= '0;
            checksum_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            for (int i = 0; i < DEPTH_BYTES; i++)
                mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            words_left_q <= words_left_d;
            checksum_q   <= checksum_d;
            done_q       <= done_d;
            error_q      <= error_d;
            in_ready_q   <= in_ready_d;
            core_reset_q <= core_reset_d;
            mem_q        <= mem_d;
        end
    end

    assign instruction_mem = mem_q;
    assign in_ready        = in_ready_q;
    assign core_reset      = core_reset_q;
    assign done            = done_q;
    assign error           = error_q;
    assign checksum        = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed scenarios plus a randomized run, each cycle checked against a
// transaction-level model of the image being loaded.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  len_words;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  imem [256];
    logic        core_reset;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    // reference model
    bit          m_load, m_done, m_err;
    int          m_idx, m_cnt;
    logic [31:0] m_ck;
    logic [7:0]  m_mem [256];

    imem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .len_words      (len_words),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .instruction_mem(imem),
        .core_reset     (core_reset),
        .done           (done),
        .error          (error),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_done = 0; m_err = 0; m_idx = 0; m_cnt = 0; m_ck = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    endtask

    task automatic model_edge();
        if (!m_load) begin
            if (start) begin
                if (len_words >= 1 && len_words <= 64) begin
                    m_load = 1; m_done = 0; m_err = 0;
                    m_idx = 0; m_cnt = int'(len_words); m_ck = '0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (in_valid) begin
            for (int k = 0; k < 4; k++) m_mem[4*m_idx+k] = in_data[31-8*k -: 8];
            m_ck = m_ck ^ in_data;
            m_idx++;
            if (m_idx == m_cnt) begin
                m_load = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int bad, first;
        bad = 0; first = -1;
        chk({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, m_load});
        chk({tag, ".done"},       {31'd0, done},       {31'd0, m_done});
        chk({tag, ".core_reset"}, {31'd0, core_reset}, {31'd0, !m_done});
        chk({tag, ".error"},      {31'd0, error},      {31'd0, m_err});
        chk({tag, ".checksum"},   checksum,            m_ck);
        for (int i = 0; i < 256; i++)
            if (imem[i] !== m_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        chk({tag, ".mem_bad_bytes"}, bad, 0);
        if (bad != 0) $display("  first differing byte at %0d", first);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_start(input int len, input string tag);
        start = 1'b1;
        len_words = 7'(len);
        cyc(tag);
        start = 1'b0;
        len_words = 7'($urandom);
    endtask

    task automatic feed(input logic [31:0] w, input bit v, input string tag);
        in_valid = v;
        in_data = w;
        cyc(tag);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc, budget;
        reset = 1'b1; start = 1'b0; len_words = '0; in_valid = 1'b0; in_data = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        cyc("idle");

        // 1: two-word image
        do_start(2, "t1.start");
        feed(32'h8C010004, 1, "t1.w0");
        feed(32'h00221820, 1, "t1.w1");
        chk("t1.bytes0_3", {imem[0], imem[1], imem[2], imem[3]}, 32'h8C010004);
        chk("t1.bytes4_7", {imem[4], imem[5], imem[6], imem[7]}, 32'h00221820);
        chk("t1.done", {31'd0, done}, 32'd1);
        chk("t1.core_reset", {31'd0, core_reset}, 32'd0);
        chk("t1.checksum", checksum, 32'h8C231824);

        // 2: gaps in in_valid
        do_start(3, "t2.start");
        feed(32'hA1B2C3D4, 1, "t2.c1");
        feed($urandom, 0, "t2.c2");
        feed(32'h11111111, 1, "t2.c3");
        feed($urandom, 0, "t2.c4");
        chk("t2.done_before_last", {31'd0, done}, 32'd0);
        feed(32'h22222222, 1, "t2.c5");
        chk("t2.done_after_5th", {31'd0, done}, 32'd1);
        chk("t2.bytes0_3", {imem[0], imem[1], imem[2], imem[3]}, 32'hA1B2C3D4);
        chk("t2.bytes8_11", {imem[8], imem[9], imem[10], imem[11]}, 32'h22222222);

        // 3: illegal lengths from IDLE
        do_reset("t3.reset");
        do_start(0, "t3.len0");
        chk("t3.err_len0", {31'd0, error}, 32'd1);
        do_start(65, "t3.len65");
        chk("t3.err_len65", {31'd0, error}, 32'd1);
        chk("t3.core_reset", {31'd0, core_reset}, 32'd1);
        feed(32'hDEADBEEF, 1, "t3.valid_idle");

        // 4: full 64-word image with random stalls
        do_start(64, "t4.start");
        acc = 0; budget = 0;
        while (acc < 64 && budget < 1000) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            feed(32'(acc), v, "t4.word");
            if (v) acc++;
            budget++;
        end
        chk("t4.budget", {31'd0, acc == 64}, 32'd1);
        chk("t4.bytes252_255", {imem[252], imem[253], imem[254], imem[255]}, 32'h0000003F);
        chk("t4.checksum", checksum, 32'h00000000);
        chk("t4.done", {31'd0, done}, 32'd1);

        // 6: reload a single word from DONE
        do_start(1, "t6.start");
        chk("t6.core_reset_rises", {31'd0, core_reset}, 32'd1);
        chk("t6.done_drops", {31'd0, done}, 32'd0);
        feed(32'hFFFFFFFF, 1, "t6.w0");
        chk("t6.bytes0_3", {imem[0], imem[1], imem[2], imem[3]}, 32'hFFFFFFFF);
        chk("t6.bytes4_7_old", {imem[4], imem[5], imem[6], imem[7]}, 32'h00000001);
        chk("t6.done", {31'd0, done}, 32'd1);

        // 5: reset in the middle of a load
        do_start(4, "t5.start");
        feed($urandom, 1, "t5.w0");
        feed($urandom, 1, "t5.w1");
        #2;
        do_reset("t5.async_reset");
        chk("t5.in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5.core_reset", {31'd0, core_reset}, 32'd1);
        chk("t5.byte0", {24'd0, imem[0]}, 32'd0);

        // randomized traffic: random starts (often illegal or during LOAD), random valid
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 15) == 0);
            len_words = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(1, 12));
            in_valid = $urandom_range(0, 1);
            in_data = $urandom;
            cyc("rand");
        end
        start = 1'b0;
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
